// File: rtl/fuzz_stim_stage.sv
// Stimulus staging between fuzz driver and core: STAGES-deep input pipeline, hold/freeze,
// core-reset stretcher, selectable dmem response latency. Optional STIM_CHECKSUM_EN adds stim_csum.
module fuzz_stim_stage #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 1,
  parameter int RST_STRETCH = 4,
  parameter int MAX_LAT     = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fuzz_reset,
  input  logic [4:0]       ddpath_addr,
  input  logic [XLEN-1:0]  ddpath_wdata,
  input  logic [XLEN-1:0]  dmem_resp_data,
  input  logic             dmem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  input  logic             hold,
  input  logic [3:0]       dmem_lat,
  output logic             core_reset,
  output logic [4:0]       c_ddpath_addr,
  output logic [XLEN-1:0]  c_ddpath_wdata,
  output logic [XLEN-1:0]  c_dmem_resp_data,
  output logic             c_dmem_resp_valid,
  output logic [XLEN-1:0]  c_imem_resp_data,
  output logic [CNT_W-1:0] stim_count
`ifdef STIM_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]  stim_csum
`endif
);

  logic [4:0]      addr_q  [STAGES];
  logic [XLEN-1:0] wdata_q [STAGES];
  logic [XLEN-1:0] dmd_q   [STAGES];
  logic            dmv_q   [STAGES];
  logic [XLEN-1:0] imem_q  [STAGES];
  logic            frst_q  [STAGES];
  logic            fz_rst_s;

  // Entry k-1 is tap k of the dmem delay line.
  logic [XLEN-1:0] lat_dat [MAX_LAT];
  logic            lat_vld [MAX_LAT];

  logic [7:0]      rst_cnt;
  logic [7:0]      rst_cnt_nxt;
  logic [3:0]      lat_eff;
  logic            stim_inc;
  logic            sel_vld;
  logic [XLEN-1:0] sel_dat;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        dmd_q[i]   <= '0;
        dmv_q[i]   <= 1'b0;
        imem_q[i]  <= '0;
        frst_q[i]  <= 1'b0;
      end
    end else if (!hold) begin
      addr_q[0]  <= ddpath_addr;
      wdata_q[0] <= ddpath_wdata;
      dmd_q[0]   <= dmem_resp_data;
      dmv_q[0]   <= dmem_resp_valid;
      imem_q[0]  <= imem_resp_data;
      frst_q[0]  <= fuzz_reset;
      for (int i = 1; i < STAGES; i++) begin
        addr_q[i]  <= addr_q[i-1];
        wdata_q[i] <= wdata_q[i-1];
        dmd_q[i]   <= dmd_q[i-1];
        dmv_q[i]   <= dmv_q[i-1];
        imem_q[i]  <= imem_q[i-1];
        frst_q[i]  <= frst_q[i-1];
      end
    end
  end

  assign fz_rst_s         = frst_q[STAGES-1];
  assign c_ddpath_addr    = addr_q[STAGES-1];
  assign c_ddpath_wdata   = wdata_q[STAGES-1];
  assign c_imem_resp_data = imem_q[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        lat_dat[k] <= '0;
        lat_vld[k] <= 1'b0;
      end
    end else if (!hold) begin
      lat_dat[0] <= dmd_q[STAGES-1];
      lat_vld[0] <= dmv_q[STAGES-1];
      for (int k = 1; k < MAX_LAT; k++) begin
        lat_dat[k] <= lat_dat[k-1];
        lat_vld[k] <= lat_vld[k-1];
      end
    end
  end

  assign lat_eff = (dmem_lat > 4'(MAX_LAT)) ? 4'(MAX_LAT) : dmem_lat;

  always_comb begin
    sel_vld = dmv_q[STAGES-1];
    sel_dat = dmd_q[STAGES-1];
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (lat_eff == 4'(k)) begin
        sel_vld = lat_vld[k-1];
        sel_dat = lat_dat[k-1];
      end
    end
  end

  assign c_dmem_resp_data  = sel_dat;
  assign c_dmem_resp_valid = sel_vld & ~core_reset;

  // A staged fuzz reset reloads even when the counter would otherwise expire this edge.
  always_comb begin
    rst_cnt_nxt = rst_cnt;
    if (fz_rst_s) begin
      rst_cnt_nxt = 8'(RST_STRETCH);
    end else if (rst_cnt != 8'd0) begin
      rst_cnt_nxt = rst_cnt - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rst_cnt <= 8'(RST_STRETCH);
    end else if (!hold) begin
      rst_cnt <= rst_cnt_nxt;
    end
  end

  assign core_reset = (rst_cnt != 8'd0);

  // Count edges that leave the core out of reset, so the first released cycle reads 1.
  assign stim_inc = !hold && (rst_cnt_nxt == 8'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      stim_count <= '0;
    end else if (stim_inc && (stim_count != {CNT_W{1'b1}})) begin
      stim_count <= stim_count + CNT_W'(1);
    end
  end

`ifdef STIM_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stim_csum <= '0;
    end else if (stim_inc && (stim_count != {CNT_W{1'b1}})) begin
      stim_csum <= {stim_csum[XLEN-2:0], stim_csum[XLEN-1]} ^ c_imem_resp_data
                   ^ c_ddpath_wdata ^ {{(XLEN-5){1'b0}}, c_ddpath_addr};
    end
  end
`endif

endmodule

// File: tb/tb_fuzz_stim_stage.sv
// Directed bench for fuzz_stim_stage: instance a uses STAGES=2, instance b uses STAGES=1, CNT_W=4.
module tb_fuzz_stim_stage;
  localparam int SA = 2;

  logic        clock = 1'b0;
  logic        reset, fuzz_reset, hold, dmem_resp_valid;
  logic [4:0]  ddpath_addr;
  logic [31:0] ddpath_wdata, dmem_resp_data, imem_resp_data;
  logic [3:0]  dmem_lat;

  logic        a_cr, a_dmv, b_cr, b_dmv;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_wdata, a_dmd, a_imem, b_wdata, b_dmd, b_imem;
  logic [31:0] a_stim;
  logic [3:0]  b_stim;
`ifdef STIM_CHECKSUM_EN
  logic [31:0] a_csum, b_csum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;
  exp_t q_imem[$];
  exp_t q_wdata[$];

  localparam bit [0:6] A_CR = 7'b0011110;
  localparam bit [0:6] B_CR = 7'b0111100;
  int A_SC [7] = '{2, 3, 3, 3, 3, 3, 4};
  int B_SC [7] = '{2, 2, 2, 2, 2, 3, 4};
  localparam bit [0:4] A_V2 = 5'b00010;
  localparam bit [0:4] B_V2 = 5'b00100;
  localparam bit [0:5] A_V3 = 6'b000010;
  localparam bit [0:5] B_V3 = 6'b000100;

  always #5 clock = ~clock;

  fuzz_stim_stage #(.XLEN(32), .STAGES(2), .RST_STRETCH(4), .MAX_LAT(3), .CNT_W(32)) u_a (
    .clock(clock), .reset(reset), .fuzz_reset(fuzz_reset), .ddpath_addr(ddpath_addr),
    .ddpath_wdata(ddpath_wdata), .dmem_resp_data(dmem_resp_data), .dmem_resp_valid(dmem_resp_valid),
    .imem_resp_data(imem_resp_data), .hold(hold), .dmem_lat(dmem_lat), .core_reset(a_cr),
    .c_ddpath_addr(a_addr), .c_ddpath_wdata(a_wdata), .c_dmem_resp_data(a_dmd),
    .c_dmem_resp_valid(a_dmv), .c_imem_resp_data(a_imem), .stim_count(a_stim)
`ifdef STIM_CHECKSUM_EN
    , .stim_csum(a_csum)
`endif
  );

  fuzz_stim_stage #(.XLEN(32), .STAGES(1), .RST_STRETCH(4), .MAX_LAT(3), .CNT_W(4)) u_b (
    .clock(clock), .reset(reset), .fuzz_reset(fuzz_reset), .ddpath_addr(ddpath_addr),
    .ddpath_wdata(ddpath_wdata), .dmem_resp_data(dmem_resp_data), .dmem_resp_valid(dmem_resp_valid),
    .imem_resp_data(imem_resp_data), .hold(hold), .dmem_lat(dmem_lat), .core_reset(b_cr),
    .c_ddpath_addr(b_addr), .c_ddpath_wdata(b_wdata), .c_dmem_resp_data(b_dmd),
    .c_dmem_resp_valid(b_dmv), .c_imem_resp_data(b_imem), .stim_count(b_stim)
`ifdef STIM_CHECKSUM_EN
    , .stim_csum(b_csum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and retire any scoreboard entries due now.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (q_imem.size() > 0 && q_imem[0].due == cyc) begin
      chk("a_imem_sb", 64'(a_imem), 64'(q_imem[0].val));
      void'(q_imem.pop_front());
    end
    if (q_wdata.size() > 0 && q_wdata[0].due == cyc) begin
      chk("a_wdata_sb", 64'(a_wdata), 64'(q_wdata[0].val));
      void'(q_wdata.pop_front());
    end
  endtask

  task automatic push_imem(input logic [31:0] v);
    exp_t e;
    imem_resp_data = v;
    e.due = cyc + SA;
    e.val = v;
    q_imem.push_back(e);
  endtask

  task automatic push_wdata(input logic [31:0] v);
    exp_t e;
    ddpath_wdata = v;
    e.due = cyc + SA;
    e.val = v;
    q_wdata.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fuzz_reset = 1'b0; hold = 1'b0; dmem_resp_valid = 1'b0;
    ddpath_addr = 5'd0; ddpath_wdata = 32'd0; dmem_resp_data = 32'd0;
    imem_resp_data = 32'd0; dmem_lat = 4'd0;

    // Reset state
    step();
    chk("a_rst_addr", 64'(a_addr), 64'd0);
    chk("a_rst_wdata", 64'(a_wdata), 64'd0);
    chk("a_rst_imem", 64'(a_imem), 64'd0);
    chk("a_rst_dmd", 64'(a_dmd), 64'd0);
    chk("a_rst_dmv", 64'(a_dmv), 64'd0);
    chk("a_rst_cr", 64'(a_cr), 64'd1);
    chk("a_rst_stim", 64'(a_stim), 64'd0);
    chk("b_rst_addr", 64'(b_addr), 64'd0);
    chk("b_rst_wdata", 64'(b_wdata), 64'd0);
    chk("b_rst_imem", 64'(b_imem), 64'd0);
    chk("b_rst_dmd", 64'(b_dmd), 64'd0);
    chk("b_rst_dmv", 64'(b_dmv), 64'd0);
    chk("b_rst_cr", 64'(b_cr), 64'd1);
    chk("b_rst_stim", 64'(b_stim), 64'd0);

    // Pipeline latency and reset stretch after harness reset
    reset = 1'b0;
    push_imem(32'h0000_0013);
    step();
    chk("a_cr_post_rst", 64'(a_cr), 64'd1);
    push_imem(32'h0010_0093);
    step();
    chk("a_cr_post_rst", 64'(a_cr), 64'd1);
    push_imem(32'h0020_0113);
    step();
    chk("a_cr_post_rst", 64'(a_cr), 64'd1);
    chk("a_stim_in_rst", 64'(a_stim), 64'd0);
    imem_resp_data = 32'd0;
    step();
    chk("a_cr_released", 64'(a_cr), 64'd0);
    chk("a_stim_first", 64'(a_stim), 64'd1);
    chk("b_stim_first", 64'(b_stim), 64'd1);

    // Single-cycle fuzz_reset pulse
    fuzz_reset = 1'b1;
    step();
    fuzz_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      chk("b_cr_pulse", 64'(B_CR[i]), 64'(b_cr));
      chk("a_cr_pulse", 64'(A_CR[i]), 64'(a_cr));
      chk("b_stim_pulse", 64'(b_stim), 64'(B_SC[i]));
      chk("a_stim_pulse", 64'(a_stim), 64'(A_SC[i]));
    end

    // Hold freezes pipeline and count
    push_wdata(32'h0F);
    step();
    step();
    chk("a_stim_prehold", 64'(a_stim), 64'd6);
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ddpath_wdata = 32'h10 + 32'(j);
      step();
      chk("a_wdata_hold", 64'(a_wdata), 64'h0F);
      chk("b_wdata_hold", 64'(b_wdata), 64'h0F);
      chk("a_stim_hold", 64'(a_stim), 64'd6);
      chk("b_stim_hold", 64'(b_stim), 64'd6);
    end
    hold = 1'b0;
    push_wdata(32'h20);
    step();
    chk("a_wdata_unhold", 64'(a_wdata), 64'h0F);
    chk("b_wdata_unhold", 64'(b_wdata), 64'h20);
    chk("a_stim_unhold", 64'(a_stim), 64'd7);
    step();

    // dmem latency 2
    dmem_lat = 4'd2;
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 32'hDEAD_BEEF;
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_data = 32'd0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      chk("a_dmv_lat2", 64'(a_dmv), 64'(A_V2[i]));
      chk("b_dmv_lat2", 64'(b_dmv), 64'(B_V2[i]));
      if (A_V2[i]) chk("a_dmd_lat2", 64'(a_dmd), 64'hDEAD_BEEF);
      if (B_V2[i]) chk("b_dmd_lat2", 64'(b_dmd), 64'hDEAD_BEEF);
    end

    // dmem latency 9 saturates to 3
    dmem_lat = 4'd9;
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 32'hDEAD_BEEF;
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_data = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk("a_dmv_lat9", 64'(a_dmv), 64'(A_V3[i]));
      chk("b_dmv_lat9", 64'(b_dmv), 64'(B_V3[i]));
      if (A_V3[i]) chk("a_dmd_lat9", 64'(a_dmd), 64'hDEAD_BEEF);
      if (B_V3[i]) chk("b_dmd_lat9", 64'(b_dmd), 64'hDEAD_BEEF);
    end

    // Response landing during core_reset has valid masked, data intact
    dmem_lat = 4'd1;
    fuzz_reset = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_resp_data = 32'hDEAD_BEEF;
    step();
    fuzz_reset = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data = 32'd0;
    step();
    chk("b_cr_supp", 64'(b_cr), 64'd1);
    chk("b_dmv_supp", 64'(b_dmv), 64'd0);
    chk("b_dmd_supp", 64'(b_dmd), 64'hDEAD_BEEF);
    step();
    chk("a_cr_supp", 64'(a_cr), 64'd1);
    chk("a_dmv_supp", 64'(a_dmv), 64'd0);
    chk("a_dmd_supp", 64'(a_dmd), 64'hDEAD_BEEF);

    // Mid-stream reset with hold asserted
    dmem_lat = 4'd0;
    ddpath_addr = 5'd5;
    ddpath_wdata = 32'h66;
    imem_resp_data = 32'h55;
    dmem_resp_data = 32'h77;
    for (int i = 0; i < 8; i++) step();
    chk("a_imem_pre", 64'(a_imem), 64'h55);
    chk("a_addr_pre", 64'(a_addr), 64'd5);
    chk("a_cr_pre", 64'(a_cr), 64'd0);
    hold = 1'b1;
    reset = 1'b1;
    step();
    chk("a_mrst_addr", 64'(a_addr), 64'd0);
    chk("a_mrst_wdata", 64'(a_wdata), 64'd0);
    chk("a_mrst_imem", 64'(a_imem), 64'd0);
    chk("a_mrst_dmd", 64'(a_dmd), 64'd0);
    chk("a_mrst_dmv", 64'(a_dmv), 64'd0);
    chk("a_mrst_cr", 64'(a_cr), 64'd1);
    chk("a_mrst_stim", 64'(a_stim), 64'd0);
    chk("b_mrst_imem", 64'(b_imem), 64'd0);
    chk("b_mrst_cr", 64'(b_cr), 64'd1);
    chk("b_mrst_stim", 64'(b_stim), 64'd0);

    // Saturation of a 4-bit stim_count
    reset = 1'b0;
    hold = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 18) begin
        chk("b_stim_sat15", 64'(b_stim), 64'hF);
        chk("a_stim_18", 64'(a_stim), 64'd15);
      end
      if (i == 19) begin
        chk("b_stim_nowrap", 64'(b_stim), 64'hF);
        chk("a_stim_19", 64'(a_stim), 64'd16);
      end
    end
    chk("b_stim_final", 64'(b_stim), 64'hF);
    chk("a_stim_final", 64'(a_stim), 64'd22);

    chk("sb_drain", 64'(q_imem.size() + q_wdata.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_stim_stage.md
Name: fuzz_stim_stage

Overview:
- Parametrised stimulus-staging front end between the fuzz driver and a Sodor-class core.
- Registers every fuzz-driven core input through a configurable-depth pipeline.
- Adds three controls on top of plain input registering: a stimulus hold/freeze mode, a core-reset stretcher, and a programmable data-memory response latency.
- Keeps a saturating count of applied stimulus cycles for coverage bookkeeping.

Parameters:
- XLEN, 32, width of the data buses (ddpath_wdata, dmem/imem response data).
- STAGES, 1, pipeline depth from inputs to core-facing outputs; legal range 1..8.
- RST_STRETCH, 4, minimum number of cycles core_reset stays asserted after its last trigger; legal range 1..255.
- MAX_LAT, 3, maximum extra dmem response delay in cycles; legal range 1..15.
- CNT_W, 32, width of stim_count.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  harness reset.
- fuzz_reset  in  1  fuzz-driven core reset request.
- ddpath_addr  in  5  debug datapath register address.
- ddpath_wdata  in  XLEN  debug datapath write data.
- dmem_resp_data  in  XLEN  data-memory response data.
- dmem_resp_valid  in  1  data-memory response valid.
- imem_resp_data  in  XLEN  instruction-memory response data.
- hold  in  1  freeze all stimulus state this cycle.
- dmem_lat  in  4  extra dmem response delay selector.
- core_reset  out  1  reset to the core.
- c_ddpath_addr  out  5  staged ddpath_addr.
- c_ddpath_wdata  out  XLEN  staged ddpath_wdata.
- c_dmem_resp_data  out  XLEN  staged, latency-shifted dmem data.
- c_dmem_resp_valid  out  1  staged, latency-shifted dmem valid.
- c_imem_resp_data  out  XLEN  staged imem data.
- stim_count  out  CNT_W  applied-stimulus cycle count.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- On reset:
  - All pipeline and latency registers clear to 0, so every c_* output reads 0 on the first cycle after reset.
  - The stretch counter loads RST_STRETCH; core_reset = 1.
  - stim_count = 0.
- Pipeline, when hold = 0: each input advances one stage per clock. c_ddpath_addr, c_ddpath_wdata and c_imem_resp_data equal the inputs sampled exactly STAGES edges earlier. fuzz_reset travels through the same pipeline; its staged copy is fz_rst_s.
- Hold, when hold = 1 at an edge:
  - No pipeline stage, latency-line entry, stretch counter or stim_count updates.
  - Outputs repeat their previous values, and inputs presented that cycle are discarded.
  - hold is ignored while reset = 1; reset wins.
- Reset stretcher:
  - The counter reloads RST_STRETCH when reset = 1, or when hold = 0 and fz_rst_s = 1.
  - Otherwise, when hold = 0 and the counter is non-zero, it decrements.
  - core_reset = (counter != 0), registered. Example: a single-cycle fz_rst_s pulse gives core_reset high for exactly RST_STRETCH cycles.
- dmem latency:
  - The staged dmem valid/data feed a MAX_LAT-entry shift line that shifts only when hold = 0.
  - lat_eff = min(dmem_lat, MAX_LAT).
  - lat_eff = 0 selects the pipeline output directly. lat_eff = k selects tap k, adding k cycles.
  - dmem_lat is sampled every cycle with no synchronisation. Changing it mid-stream may duplicate or drop a response; this is permitted.
  - While core_reset = 1, c_dmem_resp_valid is forced to 0; data still passes.
- stim_count: increments by 1 on each edge with reset = 0, hold = 0 and core_reset = 0. It saturates at all-ones and never wraps.
- Simultaneous events: reset overrides hold and fz_rst_s. When fz_rst_s = 1 and the counter reaches 1 on the same edge, the reload wins.

Optional Feature:
- Macro: STIM_CHECKSUM_EN.
- When defined:
  - Adds output stim_csum [XLEN-1:0], reset to 0.
  - On each edge where stim_count increments: stim_csum <= {stim_csum[XLEN-2:0], stim_csum[XLEN-1]} ^ c_imem_resp_data ^ c_ddpath_wdata ^ {{XLEN-5{1'b0}}, c_ddpath_addr}.
  - Used to compare stimulus streams across runs.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- STAGES=2, reset for 1 cycle, then imem_resp_data = 0x00000013, 0x00100093, 0x00200113 on successive cycles -> c_imem_resp_data shows each value 2 cycles later. core_reset stays 1 for 4 cycles after reset drops. stim_count = 1 on the first cycle core_reset = 0.
- Drive a 1-cycle fuzz_reset pulse with STAGES=1, RST_STRETCH=4 -> core_reset rises 2 edges later and stays high exactly 4 cycles; stim_count is frozen throughout.
- hold = 1 for 3 cycles while ddpath_wdata counts 0x10, 0x11, 0x12 -> c_ddpath_wdata holds its prior value; 0x10..0x12 never appear; stim_count is unchanged.
- dmem_lat = 2, then 9 (saturates to 3), with a dmem_resp_valid pulse carrying data 0xDEADBEEF -> the pulse appears at STAGES+2 and STAGES+3 cycles respectively; valid is suppressed if it lands while core_reset = 1.
- Assert reset mid-stream with hold = 1 -> all c_* outputs = 0, core_reset = 1 and stim_count = 0 on the next cycle.
- CNT_W=4, run 20 active cycles -> stim_count stops at 0xF.
